// File: rtl/bus_cycle_master.sv
// Bus cycle generator: one accepted valid/ready command becomes a T1-T2-T3-T4 cycle on the shared bus.
// Define READY_WAIT_EN to add the READY input, TW wait states and the rsp_err timeout.
module bus_cycle_master #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 8
`ifdef READY_WAIT_EN
   ,
   parameter int MAX_WAIT = 15
`endif
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic              req_iom,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              ALE,
   output logic [ADDR_W-1:0] Address,
   output logic              IOM,
   output logic              RD,
   output logic              WR,
   inout  wire  [DATA_W-1:0] Data
`ifdef READY_WAIT_EN
   ,
   input  logic              READY
`endif
);

`ifdef READY_WAIT_EN
   typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_T4, S_TW} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_T4} state_t;
`endif

   state_t            state_q;
   logic              ale_q;
   logic              rd_q;
   logic              wr_q;
   logic              iom_q;
   logic              write_q;
   logic              drive_q;
   logic              rsp_valid_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              finish;

`ifdef READY_WAIT_EN
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   logic [WAIT_W-1:0] wait_q;
   logic              err_q;
   logic              timeout;

   // The strobe phase ends when the slave is ready or the wait budget is spent.
   assign timeout = (state_q == S_TW) && !READY && (wait_q == WAIT_W'(MAX_WAIT));
   assign finish  = ((state_q == S_T3) || (state_q == S_TW)) && (READY || timeout);
   assign rsp_err = err_q;
`else
   assign finish  = (state_q == S_T3);
   assign rsp_err = 1'b0;
`endif

   assign req_ready = (state_q == S_IDLE) && !RESET;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;
   assign ALE       = ale_q;
   assign Address   = addr_q;
   assign IOM       = iom_q;
   assign RD        = rd_q;
   assign WR        = wr_q;
   assign Data      = drive_q ? wdata_q : {DATA_W{1'bz}};

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= S_IDLE;
         ale_q       <= 1'b0;
         rd_q        <= 1'b1;
         wr_q        <= 1'b1;
         iom_q       <= 1'b0;
         addr_q      <= '0;
         drive_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
`ifdef READY_WAIT_EN
         err_q       <= 1'b0;
         wait_q      <= '0;
`endif
      end else if (finish) begin
         // Edge ending the strobe phase: release the bus and report completion in T4.
         state_q     <= S_T4;
         rd_q        <= 1'b1;
         wr_q        <= 1'b1;
         drive_q     <= 1'b0;
         rsp_valid_q <= 1'b1;
`ifdef READY_WAIT_EN
         err_q       <= timeout;
         if (!write_q && !timeout) begin
            rdata_q <= Data;
         end
`else
         if (!write_q) begin
            rdata_q <= Data;
         end
`endif
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req_valid && req_ready) begin
                  addr_q  <= req_addr;
                  iom_q   <= req_iom;
                  write_q <= req_write;
                  wdata_q <= req_wdata;
                  ale_q   <= 1'b1;
                  state_q <= S_T1;
               end
            end
            S_T1: begin
               ale_q <= 1'b0;
               if (write_q) begin
                  wr_q    <= 1'b0;
                  drive_q <= 1'b1;
               end else begin
                  rd_q <= 1'b0;
               end
               state_q <= S_T2;
            end
            S_T2: state_q <= S_T3;
`ifdef READY_WAIT_EN
            S_T3: begin
               wait_q  <= WAIT_W'(1);
               state_q <= S_TW;
            end
            S_TW: wait_q <= wait_q + WAIT_W'(1);
            S_T4: begin
               err_q   <= 1'b0;
               state_q <= S_IDLE;
            end
`else
            S_T4: state_q <= S_IDLE;
`endif
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_cycle_master.sv
// Directed bus-cycle scenarios against a small IO slave model; responses checked through a scoreboard queue.
`timescale 1ns/1ps
module tb_bus_cycle_master;
   localparam int ADDR_W = 20;
   localparam int DATA_W = 8;

   typedef struct packed {
      logic [DATA_W-1:0] rdata;
      logic              err;
      logic              chk;
   } exp_t;

   logic              CLK       = 1'b0;
   logic              RESET     = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_write = 1'b0;
   logic              req_iom   = 1'b0;
   logic [ADDR_W-1:0] req_addr  = '0;
   logic [DATA_W-1:0] req_wdata = '0;
   logic              req_ready;
   logic              rsp_valid;
   logic              rsp_err;
   logic [DATA_W-1:0] rsp_rdata;
   logic              ALE;
   logic              IOM;
   logic              RD;
   logic              WR;
   logic [ADDR_W-1:0] Address;
   wire  [DATA_W-1:0] Data;
`ifdef READY_WAIT_EN
   logic              READY     = 1'b1;
   int                ready_low = 0;
`endif

   int checks = 0, errors = 0;
   int cyc = 0, acc_cyc = 0, rsp_cyc = -1;
   int ale_cnt = 0, rd_cnt = 0, wr_cnt = 0, wd_bad = 0, overlap = 0;
   int acc1 = 0, acc2 = 0;
   logic [DATA_W-1:0] cur_wdata = '0;
   logic [DATA_W-1:0] last_rd   = '0;
   exp_t sb[$];

   always #5 CLK = ~CLK;

   bus_cycle_master dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_iom   (req_iom),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .ALE       (ALE),
      .Address   (Address),
      .IOM       (IOM),
      .RD        (RD),
      .WR        (WR),
      .Data      (Data)
`ifdef READY_WAIT_EN
      ,
      .READY     (READY)
`endif
   );

   // IO slave occupying 0xFF00-0xFF0F; only answers when IOM is high.
   logic [DATA_W-1:0] mem [16] = '{3: 8'h5A, default: 8'h00};
   logic              slv_sel;
   assign slv_sel = IOM && (Address[ADDR_W-1:4] == 16'h0FF0);
   assign Data    = (slv_sel && !RD) ? mem[Address[3:0]] : 'z;
   always @(posedge CLK) if (slv_sel && !WR) mem[Address[3:0]] <= Data;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      exp_t e;
      @(negedge CLK);
      cyc++;
      if (ALE) ale_cnt++;
      if (!RD) rd_cnt++;
      if (!WR) wr_cnt++;
      if (!RD && !WR) overlap++;
      if (!WR && (Data !== cur_wdata)) wd_bad++;
`ifdef READY_WAIT_EN
      READY = !(((rd_cnt + wr_cnt) >= 2) && ((rd_cnt + wr_cnt) < 2 + ready_low));
`endif
      if (rsp_valid) begin
         rsp_cyc = cyc;
         if (sb.size() == 0) begin
            check("unexpected_rsp", 32'(rsp_valid), 32'd0);
         end else begin
            e = sb.pop_front();
            if (e.chk) check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
            check("rsp_err", 32'(rsp_err), 32'(e.err));
         end
      end
   endtask

   task automatic push(input logic [DATA_W-1:0] d, input logic err, input logic chk);
      exp_t e;
      e.rdata = d;
      e.err   = err;
      e.chk   = chk;
      sb.push_back(e);
   endtask

   // Present one request at an IDLE negedge, then scramble the inputs once it is taken.
   task automatic start(input logic wr, input logic iom, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] wd);
      check("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_write = wr;
      req_iom   = iom;
      req_addr  = a;
      req_wdata = wd;
      cur_wdata = wd;
      acc_cyc   = cyc;
      ale_cnt = 0; rd_cnt = 0; wr_cnt = 0; wd_bad = 0;
      tick();
      req_valid = 1'b0;
      req_write = ~wr;
      req_iom   = ~iom;
      req_addr  = ~a;
      req_wdata = ~wd;
   endtask

   task automatic xfer(input string tag, input logic wr, input logic iom,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic chk, input logic err, input int lat, input int stb);
      push((wr || err) ? last_rd : d, err, chk);
      start(wr, iom, a, d);
      for (int n = 0; n < 40 && rsp_cyc < acc_cyc; n++) tick();
      check({tag, "_latency"}, 32'(rsp_cyc - acc_cyc), 32'(lat));
      check({tag, "_ale_cycles"}, ale_cnt, 32'd1);
      check({tag, "_rd_low"}, rd_cnt, wr ? 32'd0 : 32'(stb));
      check({tag, "_wr_low"}, wr_cnt, wr ? 32'(stb) : 32'd0);
      if (wr) check({tag, "_wdata_bad"}, wd_bad, 32'd0);
      check({tag, "_addr_hold"}, 32'(Address), 32'(a));
      check({tag, "_iom_hold"}, 32'(IOM), 32'(iom));
      if (!wr && !err && chk) last_rd = d;
      tick();
   endtask

   initial begin
      repeat (3) tick();
      check("rst_ale", 32'(ALE), 32'd0);
      check("rst_rd", 32'(RD), 32'd1);
      check("rst_wr", 32'(WR), 32'd1);
      check("rst_iom", 32'(IOM), 32'd0);
      check("rst_addr", 32'(Address), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      RESET = 1'b0;
      #1;
      check("post_rst_ready", 32'(req_ready), 32'd1);
      tick();

      xfer("rd_io", 1'b0, 1'b1, 20'hFF03, 8'h5A, 1'b1, 1'b0, 4, 2);
      xfer("wr_io", 1'b1, 1'b1, 20'hFF07, 8'hC3, 1'b1, 1'b0, 4, 2);
      xfer("rd_back", 1'b0, 1'b1, 20'hFF07, 8'hC3, 1'b1, 1'b0, 4, 2);

      // Two requests queued behind a held req_valid.
      push(8'h5A, 1'b0, 1'b1);
      push(8'h5A, 1'b0, 1'b1);
      check("b2b_ready1", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_write = 1'b0; req_iom = 1'b1; req_addr = 20'hFF03;
      acc1 = cyc;
      tick();
      req_write = 1'b1; req_addr = 20'hFF09; req_wdata = 8'h77; cur_wdata = 8'h77;
      while (!req_ready && (cyc - acc1) < 12) tick();
      check("b2b_accept_gap", 32'(cyc - acc1), 32'd5);
      acc2 = cyc;
      tick();
      req_valid = 1'b0;
      for (int n = 0; n < 20 && rsp_cyc <= acc2; n++) tick();
      check("b2b_second_latency", 32'(rsp_cyc - acc2), 32'd4);
      tick();
      last_rd = 8'h5A;
      xfer("rd_b2b", 1'b0, 1'b1, 20'hFF09, 8'h77, 1'b1, 1'b0, 4, 2);

      // Reset lands during T2 of a write.
      start(1'b1, 1'b1, 20'hFF0A, 8'h99);
      tick();
      RESET = 1'b1;
      tick();
      check("abort_wr", 32'(WR), 32'd1);
      check("abort_rd", 32'(RD), 32'd1);
      check("abort_ale", 32'(ALE), 32'd0);
      check("abort_ready_in_rst", 32'(req_ready), 32'd0);
      check("abort_rdata", 32'(rsp_rdata), 32'd0);
      RESET = 1'b0;
      #1;
      check("abort_ready_after", 32'(req_ready), 32'd1);
      repeat (6) tick();
      last_rd = 8'h00;

      xfer("iom_mismatch", 1'b0, 1'b0, 20'hFF03, 8'h00, 1'b0, 1'b0, 4, 2);
      xfer("rd_recover", 1'b0, 1'b1, 20'hFF03, 8'h5A, 1'b1, 1'b0, 4, 2);

`ifdef READY_WAIT_EN
      ready_low = 3;
      xfer("rd_wait3", 1'b0, 1'b1, 20'hFF07, 8'hC3, 1'b1, 1'b0, 7, 5);
      ready_low = 100;
      xfer("rd_timeout", 1'b0, 1'b1, 20'hFF03, 8'h00, 1'b1, 1'b1, 19, 17);
      ready_low = 0;
      xfer("rd_after_to", 1'b0, 1'b1, 20'hFF03, 8'h5A, 1'b1, 1'b0, 4, 2);
`endif

      check("strobe_overlap", overlap, 32'd0);
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
